// File: rtl/peripheral_arbiter_axi4_if.sv
// AXI4 bundle for the peripheral arbiter. NP ports are packed side by side,
// port k occupying bits [k*W +: W] of every field. The arbiter's master side
// uses NP = 2, its slave side NP = 1.
interface peripheral_arbiter_axi4_if #(
    parameter int NP     = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Write address channel
    logic [NP*ID_W-1:0]   awid;
    logic [NP*ADDR_W-1:0] awaddr;
    logic [NP*4-1:0]      awlen;
    logic [NP*3-1:0]      awsize;
    logic [NP*2-1:0]      awburst;
    logic [NP-1:0]        awvalid;
    logic [NP-1:0]        awready;

    // Write data channel
    logic [NP*DATA_W-1:0] wdata;
    logic [NP*STRB_W-1:0] wstrb;
    logic [NP-1:0]        wlast;
    logic [NP-1:0]        wvalid;
    logic [NP-1:0]        wready;

    // Write response channel
    logic [NP*ID_W-1:0]   bid;
    logic [NP*2-1:0]      bresp;
    logic [NP-1:0]        bvalid;
    logic [NP-1:0]        bready;

    // Read address channel
    logic [NP*ID_W-1:0]   arid;
    logic [NP*ADDR_W-1:0] araddr;
    logic [NP*4-1:0]      arlen;
    logic [NP*3-1:0]      arsize;
    logic [NP*2-1:0]      arburst;
    logic [NP-1:0]        arvalid;
    logic [NP-1:0]        arready;

    // Read data channel
    logic [NP*ID_W-1:0]   rid;
    logic [NP*DATA_W-1:0] rdata;
    logic [NP*2-1:0]      rresp;
    logic [NP-1:0]        rlast;
    logic [NP-1:0]        rvalid;
    logic [NP-1:0]        rready;

    // The side that issues transactions
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    // The side that answers transactions
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/peripheral_arbiter_axi4.sv
// Two-master to one-slave AXI4 arbiter. Write and read paths arbitrate
// independently with round-robin priority; a grant is held from address
// phase until the B handshake (writes) or the last R beat (reads).
module peripheral_arbiter_axi4 #(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    peripheral_arbiter_axi4_if.slave  m_axi,
    peripheral_arbiter_axi4_if.master s_axi,
    output logic [NUM_M-1:0]         o_wgrant,
    output logic [NUM_M-1:0]         o_rgrant
);
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rstate_t;

    wstate_t          r_wstate;
    rstate_t          r_rstate;
    logic [IDX_W-1:0] r_wptr;
    logic [IDX_W-1:0] r_widx;
    logic [IDX_W-1:0] r_rptr;
    logic [IDX_W-1:0] r_ridx;

    logic [IDX_W-1:0] w_wpick;
    logic [IDX_W-1:0] w_rpick;
    logic             w_aw_hs;
    logic             w_wlast_hs;
    logic             w_b_hs;
    logic             w_ar_hs;
    logic             w_rlast_hs;

    // First requester found when scanning upward from the pointer, wrapping.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_M;
            if (req[idx]) pick = idx[IDX_W-1:0];
        end
        return pick;
    endfunction

    // Pointer value that puts the master after g first in line.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_M - 1) ? '0 : g + 1'b1;
    endfunction

    assign w_wpick    = rr_pick(m_axi.awvalid, r_wptr);
    assign w_rpick    = rr_pick(m_axi.arvalid, r_rptr);
    assign w_aw_hs    = s_axi.awvalid[0] & s_axi.awready[0];
    assign w_wlast_hs = s_axi.wvalid[0] & s_axi.wready[0] & s_axi.wlast[0];
    assign w_b_hs     = s_axi.bvalid[0] & s_axi.bready[0];
    assign w_ar_hs    = s_axi.arvalid[0] & s_axi.arready[0];
    assign w_rlast_hs = s_axi.rvalid[0] & s_axi.rready[0] & s_axi.rlast[0];

    // Write FSM: arbitrate in IDLE, hold the grant until the B handshake.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // is computed from pre-edge values regardless of statement order.
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_wptr   <= '0;
            r_widx   <= '0;
            o_wgrant <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (|m_axi.awvalid) begin
                    r_widx   <= w_wpick;
                    o_wgrant <= NUM_M'(1) << w_wpick;
                    r_wstate <= W_ADDR;
                end
                W_ADDR: if (w_aw_hs)    r_wstate <= W_DATA;
                W_DATA: if (w_wlast_hs) r_wstate <= W_RESP;
                W_RESP: if (w_b_hs) begin
                    r_wstate <= W_IDLE;
                    o_wgrant <= '0;
                    r_wptr   <= next_idx(r_widx);
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: arbitrate in IDLE, hold the grant until the last R beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
            r_rptr   <= '0;
            r_ridx   <= '0;
            o_rgrant <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (|m_axi.arvalid) begin
                    r_ridx   <= w_rpick;
                    o_rgrant <= NUM_M'(1) << w_rpick;
                    r_rstate <= R_ADDR;
                end
                R_ADDR: if (w_ar_hs) r_rstate <= R_DATA;
                R_DATA: if (w_rlast_hs) begin
                    r_rstate <= R_IDLE;
                    o_rgrant <= '0;
                    r_rptr   <= next_idx(r_ridx);
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Route AW/W/B between the write owner and the slave; all else sees zero.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        m_axi.awready = '0;
        m_axi.wready  = '0;
        m_axi.bid     = '0;
        m_axi.bresp   = '0;
        m_axi.bvalid  = '0;
        s_axi.awid    = '0;
        s_axi.awaddr  = '0;
        s_axi.awlen   = '0;
        s_axi.awsize  = '0;
        s_axi.awburst = '0;
        s_axi.awvalid = '0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wlast   = '0;
        s_axi.wvalid  = '0;
        s_axi.bready  = '0;
        case (r_wstate)
            W_ADDR: begin
                s_axi.awid            = m_axi.awid[r_widx*ID_W +: ID_W];
                s_axi.awaddr          = m_axi.awaddr[r_widx*ADDR_W +: ADDR_W];
                s_axi.awlen           = m_axi.awlen[r_widx*4 +: 4];
                s_axi.awsize          = m_axi.awsize[r_widx*3 +: 3];
                s_axi.awburst         = m_axi.awburst[r_widx*2 +: 2];
                s_axi.awvalid         = m_axi.awvalid[r_widx];
                m_axi.awready[r_widx] = s_axi.awready[0];
            end
            W_DATA: begin
                s_axi.wdata          = m_axi.wdata[r_widx*DATA_W +: DATA_W];
                s_axi.wstrb          = m_axi.wstrb[r_widx*STRB_W +: STRB_W];
                s_axi.wlast          = m_axi.wlast[r_widx];
                s_axi.wvalid         = m_axi.wvalid[r_widx];
                m_axi.wready[r_widx] = s_axi.wready[0];
            end
            W_RESP: begin
                m_axi.bid[r_widx*ID_W +: ID_W] = s_axi.bid;
                m_axi.bresp[r_widx*2 +: 2]     = s_axi.bresp;
                m_axi.bvalid[r_widx]           = s_axi.bvalid[0];
                s_axi.bready                   = m_axi.bready[r_widx];
            end
            default: ;
        endcase
    end

    // Route AR/R between the read owner and the slave; all else sees zero.
    always_comb begin
        m_axi.arready = '0;
        m_axi.rid     = '0;
        m_axi.rdata   = '0;
        m_axi.rresp   = '0;
        m_axi.rlast   = '0;
        m_axi.rvalid  = '0;
        s_axi.arid    = '0;
        s_axi.araddr  = '0;
        s_axi.arlen   = '0;
        s_axi.arsize  = '0;
        s_axi.arburst = '0;
        s_axi.arvalid = '0;
        s_axi.rready  = '0;
        case (r_rstate)
            R_ADDR: begin
                s_axi.arid            = m_axi.arid[r_ridx*ID_W +: ID_W];
                s_axi.araddr          = m_axi.araddr[r_ridx*ADDR_W +: ADDR_W];
                s_axi.arlen           = m_axi.arlen[r_ridx*4 +: 4];
                s_axi.arsize          = m_axi.arsize[r_ridx*3 +: 3];
                s_axi.arburst         = m_axi.arburst[r_ridx*2 +: 2];
                s_axi.arvalid         = m_axi.arvalid[r_ridx];
                m_axi.arready[r_ridx] = s_axi.arready[0];
            end
            R_DATA: begin
                m_axi.rid[r_ridx*ID_W +: ID_W]       = s_axi.rid;
                m_axi.rdata[r_ridx*DATA_W +: DATA_W] = s_axi.rdata;
                m_axi.rresp[r_ridx*2 +: 2]           = s_axi.rresp;
                m_axi.rlast[r_ridx]                  = s_axi.rlast[0];
                m_axi.rvalid[r_ridx]                 = s_axi.rvalid[0];
                s_axi.rready                         = m_axi.rready[r_ridx];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_peripheral_arbiter_axi4.sv
// Directed bench for peripheral_arbiter_axi4: two master drivers, a small
// AXI4 memory slave, and hand-computed expectations for each scenario.
module tb_peripheral_arbiter_axi4;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BUDGET = 200;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] wgrant;
    logic [1:0] rgrant;

    always #5 aclk = ~aclk;

    peripheral_arbiter_axi4_if #(.NP(2), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();
    peripheral_arbiter_axi4_if #(.NP(1), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    peripheral_arbiter_axi4 #(.NUM_M(2), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .m_axi    (m_if),
        .s_axi    (s_if),
        .o_wgrant (wgrant),
        .o_rgrant (rgrant)
    );

    // Per-master drive variables
    logic [3:0]  awid_d[2];
    logic [31:0] awaddr_d[2];
    logic [3:0]  awlen_d[2];
    logic        awvalid_d[2];
    logic [31:0] wdata_d[2];
    logic        wlast_d[2];
    logic        wvalid_d[2];
    logic        bready_d[2];
    logic [3:0]  arid_d[2];
    logic [31:0] araddr_d[2];
    logic [3:0]  arlen_d[2];
    logic        arvalid_d[2];
    logic        rready_d[2];

    assign m_if.awid    = {awid_d[1], awid_d[0]};
    assign m_if.awaddr  = {awaddr_d[1], awaddr_d[0]};
    assign m_if.awlen   = {awlen_d[1], awlen_d[0]};
    assign m_if.awsize  = {3'd2, 3'd2};
    assign m_if.awburst = {2'b01, 2'b01};
    assign m_if.awvalid = {awvalid_d[1], awvalid_d[0]};
    assign m_if.wdata   = {wdata_d[1], wdata_d[0]};
    assign m_if.wstrb   = 8'hFF;
    assign m_if.wlast   = {wlast_d[1], wlast_d[0]};
    assign m_if.wvalid  = {wvalid_d[1], wvalid_d[0]};
    assign m_if.bready  = {bready_d[1], bready_d[0]};
    assign m_if.arid    = {arid_d[1], arid_d[0]};
    assign m_if.araddr  = {araddr_d[1], araddr_d[0]};
    assign m_if.arlen   = {arlen_d[1], arlen_d[0]};
    assign m_if.arsize  = {3'd2, 3'd2};
    assign m_if.arburst = {2'b01, 2'b01};
    assign m_if.arvalid = {arvalid_d[1], arvalid_d[0]};
    assign m_if.rready  = {rready_d[1], rready_d[0]};

    // Memory slave model: one write and one read outstanding, INCR bursts.
    logic [31:0] mem [0:255];
    logic        sl_aw_have, sl_b_pend, sl_ar_have;
    logic [31:0] sl_waddr, sl_raddr;
    logic [3:0]  sl_bid, sl_rid, sl_rlen, sl_rcnt;

    assign s_if.awready = !sl_aw_have && !sl_b_pend;
    assign s_if.wready  = sl_aw_have;
    assign s_if.bvalid  = sl_b_pend;
    assign s_if.bid     = sl_bid;
    assign s_if.bresp   = 2'b00;
    assign s_if.arready = !sl_ar_have;
    assign s_if.rvalid  = sl_ar_have;
    assign s_if.rid     = sl_rid;
    assign s_if.rdata   = mem[sl_raddr[9:2]];
    assign s_if.rresp   = 2'b00;
    assign s_if.rlast   = (sl_rcnt == sl_rlen);

    // Slave model state, reset from the same aresetn as the arbiter.
    always @(posedge aclk) begin
        if (!aresetn) begin
            sl_aw_have <= 1'b0;
            sl_b_pend  <= 1'b0;
            sl_ar_have <= 1'b0;
            sl_waddr   <= '0;
            sl_raddr   <= '0;
            sl_bid     <= '0;
            sl_rid     <= '0;
            sl_rlen    <= '0;
            sl_rcnt    <= '0;
        end else begin
            if (s_if.awvalid[0] && s_if.awready[0]) begin
                sl_aw_have <= 1'b1;
                sl_waddr   <= s_if.awaddr;
                sl_bid     <= s_if.awid;
            end
            if (s_if.wvalid[0] && s_if.wready[0]) begin
                for (int b = 0; b < 4; b++)
                    if (s_if.wstrb[b]) mem[sl_waddr[9:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];
                sl_waddr <= sl_waddr + 32'd4;
                if (s_if.wlast[0]) begin
                    sl_aw_have <= 1'b0;
                    sl_b_pend  <= 1'b1;
                end
            end
            if (s_if.bvalid[0] && s_if.bready[0]) sl_b_pend <= 1'b0;
            if (s_if.arvalid[0] && s_if.arready[0]) begin
                sl_ar_have <= 1'b1;
                sl_raddr   <= s_if.araddr;
                sl_rid     <= s_if.arid;
                sl_rlen    <= s_if.arlen;
                sl_rcnt    <= '0;
            end
            if (s_if.rvalid[0] && s_if.rready[0]) begin
                sl_raddr <= sl_raddr + 32'd4;
                sl_rcnt  <= sl_rcnt + 4'd1;
                if (s_if.rlast[0]) sl_ar_have <= 1'b0;
            end
        end
    end

    // Master-side monitor: B order, R beat counts, m1 activity, path overlap.
    int b_order[$];
    int b_cnt[2];
    int r_beats[2];
    int m1_activity;
    bit overlap_seen;

    always @(posedge aclk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_if.bvalid[k] && m_if.bready[k]) begin
                b_cnt[k] <= b_cnt[k] + 1;
                b_order.push_back(k);
            end
            if (m_if.rvalid[k] && m_if.rready[k]) r_beats[k] <= r_beats[k] + 1;
        end
        if (m_if.awready[1] || m_if.wready[1] || m_if.bvalid[1] || m_if.arready[1] || m_if.rvalid[1])
            m1_activity <= m1_activity + 1;
        if (wgrant == 2'b01 && rgrant == 2'b10) overlap_seen <= 1'b1;
    end

    int tests = 0;
    int fails = 0;

    logic [1:0]  wr_grant[2];
    logic [1:0]  wr_bresp[2];
    logic [3:0]  wr_bid[2];
    logic [31:0] rd_data[2][16];
    logic [15:0] rd_last[2];
    logic [3:0]  rd_id[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic abort(input string tag);
        tests++;
        fails++;
        $display("FAIL timeout waiting for %s", tag);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench stopped on timeout");
    endtask

    function automatic logic m_sig(input int sel, input int k);
        case (sel)
            0:       return m_if.awready[k];
            1:       return m_if.wready[k];
            2:       return m_if.bvalid[k];
            3:       return m_if.arready[k];
            default: return m_if.rvalid[k];
        endcase
    endfunction

    // Returns at a falling edge where the selected signal is high; the
    // handshake then completes on the following rising edge.
    task automatic wait_sig(input int sel, input int k, input string tag);
        int n = 0;
        @(negedge aclk);
        while (!m_sig(sel, k)) begin
            n++;
            if (n > BUDGET) abort(tag);
            @(negedge aclk);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {m_if.awready, m_if.wready, m_if.bvalid, m_if.arready, m_if.rvalid,
                    s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
                    wgrant, rgrant}, 64'h0);
    endtask

    task automatic m_write(input int k, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] data0, input logic [3:0] id, input bit early_w);
        if (early_w) begin
            wdata_d[k]  = data0;
            wlast_d[k]  = (len == 4'd0);
            wvalid_d[k] = 1'b1;
            repeat (2) begin
                @(negedge aclk);
                check("early_w_wready_before_aw", m_if.wready[k], 1'b0);
                @(posedge aclk); #1;
            end
        end
        awid_d[k]    = id;
        awaddr_d[k]  = addr;
        awlen_d[k]   = len;
        awvalid_d[k] = 1'b1;
        wait_sig(0, k, "awready");
        wr_grant[k] = wgrant;
        if (early_w) check("early_w_wready_in_addr", m_if.wready[k], 1'b0);
        @(posedge aclk); #1;
        awvalid_d[k] = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata_d[k]  = data0 + 32'(i);
            wlast_d[k]  = (i == int'(len));
            wvalid_d[k] = 1'b1;
            wait_sig(1, k, "wready");
            @(posedge aclk); #1;
        end
        wvalid_d[k] = 1'b0;
        wlast_d[k]  = 1'b0;
        bready_d[k] = 1'b1;
        wait_sig(2, k, "bvalid");
        wr_bresp[k] = m_if.bresp[k*2 +: 2];
        wr_bid[k]   = m_if.bid[k*4 +: 4];
        @(posedge aclk); #1;
        bready_d[k] = 1'b0;
    endtask

    task automatic m_read(input int k, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id);
        rd_last[k]   = '0;
        arid_d[k]    = id;
        araddr_d[k]  = addr;
        arlen_d[k]   = len;
        arvalid_d[k] = 1'b1;
        wait_sig(3, k, "arready");
        @(posedge aclk); #1;
        arvalid_d[k] = 1'b0;
        rready_d[k]  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            wait_sig(4, k, "rvalid");
            rd_data[k][i] = m_if.rdata[k*32 +: 32];
            rd_last[k][i] = m_if.rlast[k];
            rd_id[k]      = m_if.rid[k*4 +: 4];
            @(posedge aclk); #1;
        end
        rready_d[k] = 1'b0;
    endtask

    initial begin
        int base;
        int m1_before;
        int r0_before;
        int r1_before;

        for (int k = 0; k < 2; k++) begin
            awid_d[k] = '0;  awaddr_d[k] = '0; awlen_d[k] = '0; awvalid_d[k] = 1'b0;
            wdata_d[k] = '0; wlast_d[k] = 1'b0; wvalid_d[k] = 1'b0; bready_d[k] = 1'b0;
            arid_d[k] = '0;  araddr_d[k] = '0; arlen_d[k] = '0; arvalid_d[k] = 1'b0;
            rready_d[k] = 1'b0;
        end

        // Reset
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_quiet("reset_quiet");
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Test 1: single write then read by m0; m1 untouched
        m1_before = m1_activity;
        m_write(0, 32'h10, 4'd0, 32'hDEADBEEF, 4'h3, 1'b0);
        check("t1_wgrant", wr_grant[0], 2'b01);
        check("t1_bresp", wr_bresp[0], 2'b00);
        check("t1_bid", wr_bid[0], 4'h3);
        check("t1_b_m0", b_cnt[0], 1);
        check("t1_b_m1", b_cnt[1], 0);
        m_read(0, 32'h10, 4'd0, 4'h5);
        check("t1_rdata", rd_data[0][0], 32'hDEADBEEF);
        check("t1_rlast", rd_last[0], 16'h0001);
        check("t1_rid", rd_id[0], 4'h5);
        check("t1_m1_quiet", m1_activity - m1_before, 0);

        // m1 write so the write pointer returns to m0 before the contention test
        m_write(1, 32'h14, 4'd0, 32'h14141414, 4'h1, 1'b0);
        check("setup_wgrant_m1", wr_grant[1], 2'b10);

        // Test 2: simultaneous writes, pointer at m0
        base = b_order.size();
        fork
            m_write(0, 32'h20, 4'd0, 32'h11111111, 4'h1, 1'b0);
            m_write(1, 32'h24, 4'd0, 32'h22222222, 4'h2, 1'b0);
        join
        check("t2_b_total", b_order.size() - base, 2);
        check("t2_first", b_order[base], 0);
        check("t2_second", b_order[base+1], 1);
        check("t2_wgrant_m0", wr_grant[0], 2'b01);
        check("t2_wgrant_m1", wr_grant[1], 2'b10);
        check("t2_bid_m1", wr_bid[1], 4'h2);
        m_read(0, 32'h20, 4'd1, 4'h4);
        check("t2_rd0", rd_data[0][0], 32'h11111111);
        check("t2_rd1", rd_data[0][1], 32'h22222222);
        check("t2_rlast", rd_last[0], 16'h0002);

        // Test 3: m0 three back-to-back writes against one from m1
        base = b_order.size();
        fork
            begin
                m_write(0, 32'h28, 4'd0, 32'hA0A00001, 4'h0, 1'b0);
                m_write(0, 32'h2C, 4'd0, 32'hA0A00002, 4'h0, 1'b0);
                m_write(0, 32'h30, 4'd0, 32'hA0A00003, 4'h0, 1'b0);
            end
            m_write(1, 32'h34, 4'd0, 32'hB1B10001, 4'h8, 1'b0);
        join
        check("t3_b_total", b_order.size() - base, 4);
        check("t3_order0", b_order[base],   0);
        check("t3_order1", b_order[base+1], 1);
        check("t3_order2", b_order[base+2], 0);
        check("t3_order3", b_order[base+3], 0);

        // Test 4: m1 4-beat read burst alongside an m0 write
        r0_before    = r_beats[0];
        r1_before    = r_beats[1];
        overlap_seen = 1'b0;
        fork
            m_read(1, 32'h20, 4'd3, 4'h9);
            m_write(0, 32'h40, 4'd0, 32'h44444444, 4'h7, 1'b0);
        join
        check("t4_overlap", overlap_seen, 1'b1);
        check("t4_wgrant", wr_grant[0], 2'b01);
        check("t4_rd0", rd_data[1][0], 32'h11111111);
        check("t4_rd1", rd_data[1][1], 32'h22222222);
        check("t4_rd2", rd_data[1][2], 32'hA0A00001);
        check("t4_rd3", rd_data[1][3], 32'hA0A00002);
        check("t4_rlast", rd_last[1], 16'h0008);
        check("t4_rid", rd_id[1], 4'h9);
        check("t4_r_m0", r_beats[0] - r0_before, 0);
        check("t4_r_m1", r_beats[1] - r1_before, 4);

        // Test 5: W presented two cycles ahead of AW
        m_write(0, 32'h50, 4'd0, 32'h55AA55AA, 4'h6, 1'b1);
        check("t5_bresp", wr_bresp[0], 2'b00);
        m_read(0, 32'h50, 4'd0, 4'h2);
        check("t5_rdata", rd_data[0][0], 32'h55AA55AA);

        // Test 6: reset in the middle of an m0 burst
        awid_d[0]    = 4'h0;
        awaddr_d[0]  = 32'h70;
        awlen_d[0]   = 4'd3;
        awvalid_d[0] = 1'b1;
        wait_sig(0, 0, "t6_awready");
        @(posedge aclk); #1;
        awvalid_d[0] = 1'b0;
        wdata_d[0]   = 32'h70707070;
        wlast_d[0]   = 1'b0;
        wvalid_d[0]  = 1'b1;
        wait_sig(1, 0, "t6_wready");
        @(posedge aclk); #1;
        wdata_d[0] = 32'h70707071;
        @(negedge aclk);
        check("t6_wgrant_in_data", wgrant, 2'b01);
        @(posedge aclk); #1;
        aresetn     = 1'b0;
        wvalid_d[0] = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_quiet("t6_reset_quiet");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        base = b_order.size();
        fork
            m_write(0, 32'h60, 4'd0, 32'h60606060, 4'h3, 1'b0);
            m_write(1, 32'h64, 4'd0, 32'h64646464, 4'hC, 1'b0);
        join
        check("t6_b_total", b_order.size() - base, 2);
        check("t6_ptr_reset_first", b_order[base], 0);
        check("t6_second", b_order[base+1], 1);
        check("t6_bresp_m1", wr_bresp[1], 2'b00);
        check("t6_bid_m1", wr_bid[1], 4'hC);
        m_read(1, 32'h64, 4'd0, 4'hE);
        check("t6_rdata", rd_data[1][0], 32'h64646464);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/peripheral_arbiter_axi4.md
Name: peripheral_arbiter_axi4

Overview:
Two-master to one-slave AXI4 arbiter placed in front of the generic AXI4 slave/memory model. It lets the DMA engine and a host/test master share that single slave. Write and read paths arbitrate independently, round-robin, one transaction at a time per path. A grant is held until the transaction completes: the B handshake for writes, the last R beat for reads.

Parameters:
NUM_M, 2, number of masters (design and verification cover 2 only)
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
Signal groups are listed one channel per line. Master-side signals are packed, with master k at bits [k*W +: W].

Clock and reset:
- aclk in 1 clock
- aresetn in 1 reset, synchronous, active-low; clock aclk

Master side (per master):
- m_aw*: awid ID_W, awaddr ADDR_W, awlen 4, awsize 3, awburst 2, awvalid 1 (in); awready 1 (out)
- m_w*: wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1 (in); wready 1 (out)
- m_b*: bid ID_W, bresp 2, bvalid 1 (out); bready 1 (in)
- m_ar*: arid ID_W, araddr ADDR_W, arlen 4, arsize 3, arburst 2, arvalid 1 (in); arready 1 (out)
- m_r*: rid ID_W, rdata DATA_W, rresp 2, rlast 1, rvalid 1 (out); rready 1 (in)

Slave side:
- s_aw*, s_w*, s_b*, s_ar*, s_r*: same fields as the master side, unpacked, with directions mirrored.

Status:
- wgrant out 2: one-hot, current write owner; 0 when idle
- rgrant out 2: one-hot, current read owner; 0 when idle

Behaviour:
Reset values:
- All out-valid/ready signals are 0; wgrant = rgrant = 0.
- Write and read FSMs are in IDLE; both round-robin pointers are 0, so master 0 has first priority.

Write FSM (IDLE, ADDR, DATA, RESP):
- IDLE: if any m_awvalid, register a one-hot grant by round-robin starting at the pointer, then go to ADDR next cycle. Arbitration costs 1 cycle; all awready = 0 while in IDLE.
- ADDR: forward the granted master's AW fields to s_aw*; s_awvalid equals the granted master's awvalid; m_awready[g] = s_awready. Advance to DATA on the s_awvalid & s_awready handshake.
- DATA: route W of the granted master only; m_wready[g] = s_wready. Go to RESP on a W handshake with wlast = 1.
- RESP: m_bvalid[g] = s_bvalid; s_bready = m_bready[g]; bid and bresp pass through. On the B handshake:
  - return to IDLE and clear wgrant;
  - set the pointer to g+1 mod 2.

Read FSM (IDLE, ADDR, DATA):
- Same arbitration and ADDR handling on the AR channel.
- DATA: route s_r* to the granted master; s_rready = m_rready[g]. On an R handshake with rlast = 1, return to IDLE and rotate the pointer.

Masking:
- Non-granted masters see ready = 0 and valid = 0 on every channel.
- A W beat arriving before the AW grant stalls, because wready = 0.
- Slave-side valids are 0 outside ADDR, DATA and RESP.
- All routing is combinational from registered grant and state; the only added latency is the 1-cycle arbitration in IDLE.

Boundary cases:
- Simultaneous requests from both masters: the pointer wins. After completion the other master is granted next, even if the winner requests again immediately.
- A single requester is granted regardless of the pointer; the pointer still rotates past it.
- Write and read paths are fully independent and may be owned by different masters at once.
- A master deasserting valid in ADDR before the handshake is a protocol violation and is not supported. The grant is held.
- awlen = 0 means a single beat: DATA exits on that first beat, which must carry wlast = 1.
- IDs are passed through unmodified. Response routing uses the grant, not the ID.
- aresetn low in any state returns to the reset values on the next edge. An in-flight slave transaction is abandoned; the slave is reset from the same aresetn.

Test Plan:
1. Reset release; m0 writes 0xDEADBEEF to 0x10 (awlen = 0, wstrb = 0xF), then reads 0x10 -> wgrant = 01 for the write; B OKAY to m0 only; m0 reads back 0xDEADBEEF with rlast = 1; m1 sees no valids.
2. m0 and m1 assert awvalid in the same cycle, with 0x20 = 0x11111111 and 0x24 = 0x22222222 -> m0 is served first, then m1; each gets exactly one B; readback is correct.
3. m0 issues three back-to-back writes while m1 issues one -> order is m0, m1, m0, m0, confirming alternation under contention.
4. m1 performs a 4-beat read burst (arlen = 3) while m0 performs a concurrent write -> rgrant = 10 and wgrant = 01 overlap; R beats go only to m1; rlast is on the 4th beat.
5. m0 drives wvalid 2 cycles before awvalid -> m_wready[0] = 0 until ADDR completes; data is not lost; the memory value is correct.
6. aresetn is pulsed low during DATA of a burst -> the next cycle shows wgrant = 0, all valid/ready = 0, and the pointer = 0; a new write from m1 then completes normally.
